// File: rtl/risc8_uart_rx_if.sv
// RISC8 IO bus bundle for the UART receiver.
// Master drives strobes/address/data; slave returns rdata/valid.
interface risc8_uart_rx_if;
  logic       ren;
  logic       wen;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       valid;

  modport master (
    output ren, wen, addr, wdata,
    input  rdata, valid
  );

  modport slave (
    input  ren, wen, addr, wdata,
    output rdata, valid
  );
endinterface

// File: rtl/risc8_uart_rx.sv
// RISC8 UART receiver with IO-mapped baud/status/data registers.
// UART_DIV sets reset divisor; UART_RX_FIFO_EN selects a 4-deep FIFO.
`ifndef UART_DIV
`define UART_DIV 5
`endif

module risc8_uart_rx #(
  parameter logic [6:0] BASE = 7'h31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_in,
  risc8_uart_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  localparam logic [6:0] A_STAT = BASE + 7'd1;
  localparam logic [6:0] A_DATA = BASE + 7'd2;

  state_t     state, state_n;
  logic       s1, s2, rxs, rxs_d;
  logic [7:0] baud_div, per, half;
  logic [7:0] timer, timer_n;
  logic [7:0] sh, sh_n;
  logic [2:0] idx, idx_n;
  logic       expired, push, ferr_set;
  logic       frame_err, overrun;
  logic       full, avail, pop, wr, ovr_set;
  logic       sel_div, sel_stat, sel_data;
  logic       w_stat, rd_hit;
  logic [7:0] head, status, rd_val;

  assign rxs  = s2;
  assign per  = (baud_div == 8'd0) ? 8'd1 : baud_div;
  assign half = (per < 8'd2) ? 8'd1 : {1'b0, per[7:1]};

  assign sel_div  = bus.addr == BASE;
  assign sel_stat = bus.addr == A_STAT;
  assign sel_data = bus.addr == A_DATA;
  assign w_stat   = bus.wen && sel_stat;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rx_in;
      s2    <= s1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= 8'd0;
      idx   <= 3'd0;
      sh    <= 8'd0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    idx_n    = idx;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    expired  = timer <= 8'd1;
    unique case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = START;
          timer_n = half;
        end
      end
      START: begin
        if (!expired) begin
          timer_n = timer - 8'd1;
        end else if (!rxs) begin
          state_n = DATA;
          idx_n   = 3'd0;
          timer_n = per;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!expired) begin
          timer_n = timer - 8'd1;
        end else begin
          sh_n    = {rxs, sh[7:1]};
          timer_n = per;
          if (idx == 3'd7) state_n = STOP;
          else idx_n = idx + 3'd1;
        end
      end
      STOP: begin
        if (!expired) begin
          timer_n = timer - 8'd1;
        end else begin
          state_n  = IDLE;
          push     = rxs;
          ferr_set = !rxs;
        end
      end
    endcase
  end

  // A pop in the push cycle frees the slot, so a full buffer still accepts
  assign pop     = bus.ren && sel_data && avail;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;

  assign full  = cnt == 3'd4;
  assign avail = cnt != 3'd0;
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
    end else begin
      if (wr) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      if (wr && !pop) cnt <= cnt + 3'd1;
      else if (!wr && pop) cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= sh;
  end
`else
  logic       held;
  logic [7:0] hold;

  assign full  = held;
  assign avail = held;
  assign head  = hold;

  always_ff @(posedge clk) begin
    if (reset) held <= 1'b0;
    else if (wr) held <= 1'b1;
    else if (pop) held <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr) hold <= sh;
  end
`endif

  assign status = {4'b0, frame_err, overrun, full, avail};

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div  <= 8'(`UART_DIV);
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bus.wen && sel_div) baud_div <= bus.wdata;
      frame_err <= ferr_set
                 | (frame_err & ~(w_stat & bus.wdata[3]));
      overrun   <= ovr_set
                 | (overrun & ~(w_stat & bus.wdata[2]));
    end
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_val = 8'h00;
    unique case (1'b1)
      sel_div:  rd_val = baud_div;
      sel_stat: rd_val = status;
      sel_data: rd_val = avail ? head : 8'h00;
      default:  rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid <= 1'b0;
      bus.rdata <= 8'h00;
    end else begin
      bus.valid <= bus.ren && rd_hit;
      if (bus.ren && rd_hit) bus.rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_risc8_uart_rx.sv
// Bench for risc8_uart_rx: register vector table plus
// serial-frame sequences for sync, framing, overrun and reset.
`ifndef UART_DIV
`define UART_DIV 5
`endif

module tb_risc8_uart_rx;

  localparam logic [6:0] B  = 7'h31;
  localparam logic [6:0] B1 = 7'h32;
  localparam logic [6:0] B2 = 7'h33;

  logic clk;
  logic reset;
  logic rx_in;
  int   n_vec;
  int   n_bad;

  risc8_uart_rx_if bus ();

  risc8_uart_rx #(.BASE(B)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_in (rx_in),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [6:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic ev,
                     input logic [7:0] ed);
    n_vec++;
    if (bus.valid !== ev || bus.rdata !== ed) begin
      n_bad++;
      $display("FAIL %s: got valid=%b rdata=%h, want valid=%b rdata=%h",
               nm, bus.valid, bus.rdata, ev, ed);
    end
  endtask

  task automatic rd_now(input string nm, input logic [6:0] a,
                        input logic ev, input logic [7:0] ed);
    bus.ren  = 1'b1;
    bus.addr = a;
    @(negedge clk);
    bus.ren  = 1'b0;
    chk(nm, ev, ed);
  endtask

  task automatic rd(input string nm, input logic [6:0] a,
                    input logic ev, input logic [7:0] ed);
    @(negedge clk);
    rd_now(nm, a, ev, ed);
  endtask

  task automatic wr_now(input logic [6:0] a, input logic [7:0] d);
    bus.wen   = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wen   = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  // Five clocks per bit; returns on the negedge before the push edge
  task automatic frame(input logic [7:0] b, input logic stop,
                       input int n);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = f[i / 5];
    end
  endtask

  task automatic send(input logic [7:0] b);
    frame(b, 1'b1, 50);
  endtask

  initial begin
    logic [7:0] st_one;
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    rx_in     = 1'b1;
    bus.ren   = 1'b0;
    bus.wen   = 1'b0;
    bus.addr  = 7'h00;
    bus.wdata = 8'h00;
`ifdef UART_RX_FIFO_EN
    st_one = 8'h01;
`else
    st_one = 8'h03;
`endif

    tbl[0]  = '{1'b0, B,     8'h00, 1'b1, 8'h05};
    tbl[1]  = '{1'b0, B1,    8'h00, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, B2,    8'h00, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, B,     8'h0A, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, B,     8'h00, 1'b1, 8'h0A};
    tbl[5]  = '{1'b0, 7'h10, 8'h00, 1'b0, 8'h0A};
    tbl[6]  = '{1'b0, 7'h34, 8'h00, 1'b0, 8'h0A};
    tbl[7]  = '{1'b1, 7'h30, 8'h77, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, B,     8'h00, 1'b1, 8'h0A};
    tbl[9]  = '{1'b1, B,     8'h05, 1'b0, 8'h00};
    tbl[10] = '{1'b0, B,     8'h00, 1'b1, 8'h05};
    tbl[11] = '{1'b1, B1,    8'hFF, 1'b0, 8'h00};
    tbl[12] = '{1'b0, B1,    8'h00, 1'b1, 8'h00};
    tbl[13] = '{1'b0, 7'h30, 8'h00, 1'b0, 8'h00};

    repeat (4) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      else rd($sformatf("vec%0d", i), tbl[i].a, tbl[i].ev, tbl[i].ed);
    end

    rd("valid_pre", B, 1'b1, 8'h05);
    @(negedge clk);
    chk("valid_one_cycle", 1'b0, 8'h05);

    send(8'hA5);
    rd("a5_status", B1, 1'b1, st_one);
    rd("a5_data", B2, 1'b1, 8'hA5);
    rd("a5_status_after", B1, 1'b1, 8'h00);

    @(negedge clk);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    rd("glitch_status", B1, 1'b1, 8'h00);
    rd("glitch_data", B2, 1'b1, 8'h00);

    frame(8'h3C, 1'b0, 50);
    @(negedge clk);
    rx_in = 1'b1;
    rd("ferr_status", B1, 1'b1, 8'h08);
    rd("ferr_data", B2, 1'b1, 8'h00);
    wr(B1, 8'h08);
    rd("ferr_clear", B1, 1'b1, 8'h00);

    frame(8'h3C, 1'b0, 50);
    wr_now(B1, 8'h08);
    rx_in = 1'b1;
    rd("w1c_race", B1, 1'b1, 8'h08);
    wr(B1, 8'h08);
    rd("w1c_race_clr", B1, 1'b1, 8'h00);

`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send(8'(i));
    rd("ovr_status", B1, 1'b1, 8'h07);
    for (int i = 1; i <= 4; i++)
      rd($sformatf("ovr_pop%0d", i), B2, 1'b1, 8'(i));
    rd("ovr_empty", B2, 1'b1, 8'h00);
`else
    send(8'h01);
    send(8'h02);
    rd("ovr_status", B1, 1'b1, 8'h07);
    rd("ovr_pop1", B2, 1'b1, 8'h01);
    rd("ovr_empty", B2, 1'b1, 8'h00);
`endif
    rd("ovr_sticky", B1, 1'b1, 8'h04);
    wr(B1, 8'h04);
    rd("ovr_clear", B1, 1'b1, 8'h00);

`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
    rd("full_status", B1, 1'b1, 8'h03);
    send(8'h15);
    rd_now("pp_pop", B2, 1'b1, 8'h11);
    rd("pp_status", B1, 1'b1, 8'h03);
    for (int i = 0; i < 4; i++)
      rd($sformatf("pp_drain%0d", i), B2, 1'b1, 8'h12 + 8'(i));
`else
    send(8'h11);
    rd("full_status", B1, 1'b1, 8'h03);
    send(8'h12);
    rd_now("pp_pop", B2, 1'b1, 8'h11);
    rd("pp_status", B1, 1'b1, 8'h03);
    rd("pp_drain0", B2, 1'b1, 8'h12);
`endif
    rd("pp_final", B1, 1'b1, 8'h00);

    send(8'h77);
    frame(8'h3C, 1'b0, 50);
    @(negedge clk);
    rx_in = 1'b1;
    frame(8'h5A, 1'b1, 22);
    wr_now(B, 8'h20);
    reset = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 1'b0, 8'h00);
    repeat (60) @(negedge clk);
    rd("rst_status", B1, 1'b1, 8'h00);
    rd("rst_data", B2, 1'b1, 8'h00);
    rd("rst_baud", B, 1'b1, 8'(`UART_DIV));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
